// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive path: FSM encoding, parity
// selectors, legal oversample ratios and the majority vote used by the sampler.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler: captures RX_IN on three consecutive oversample clocks around
// the bit centre and presents the majority value with a one-cycle valid strobe.
module uart_rx_sampler
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned PRE_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             rx_in,
  input  logic [PRE_W-1:0] prescale,
  input  logic [PRE_W-1:0] edge_cnt,
  output logic             smp,
  output logic             smp_vld
);

  logic [PRE_W-1:0] half;
  logic [PRE_W-1:0] half_m1;
  logic [PRE_W-1:0] half_p1;
  logic [PRE_W-1:0] half_p2;
  logic [2:0]       cap_q;
  logic [2:0]       cap_d;

  assign half    = prescale >> 1;
  assign half_m1 = half - PRE_W'(1);
  assign half_p1 = half + PRE_W'(1);
  assign half_p2 = half + PRE_W'(2);

  always_comb begin
    cap_d = cap_q;
    if (!enable) begin
      cap_d = '0;
    end else begin
      if (edge_cnt == half_m1) cap_d[0] = rx_in;
      if (edge_cnt == half)    cap_d[1] = rx_in;
      if (edge_cnt == half_p1) cap_d[2] = rx_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  // The third capture lands on the edge into half+2, so the vote is complete there.
  assign smp     = majority3(cap_q);
  assign smp_vld = enable && (edge_cnt == half_p2);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, LSB-first deserialisation,
// optional parity and stop-bit checks, one result pulse per frame.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRE_W      = 6,
  parameter int unsigned BIT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRE_W-1:0]      Prescale,
  input  logic [PRE_W-1:0]      edge_cnt,
  input  logic [BIT_W-1:0]      bit_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_e             state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRE_W-1:0]      prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic smp;
  logic smp_vld;
  logic end_bit;
  logic exp_par;

  assign cnt_enable = (state_q != StIdle);
  assign end_bit    = (edge_cnt == (prescale_q - PRE_W'(1)));
  assign exp_par    = (^shreg_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler #(
    .PRE_W (PRE_W)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_enable),
    .rx_in    (RX_IN),
    .prescale (prescale_q),
    .edge_cnt (edge_cnt),
    .smp      (smp),
    .smp_vld  (smp_vld)
  );

  always_comb begin
    state_d    = state_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Frame configuration is frozen from the last idle cycle onwards.
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        prescale_d = Prescale;
        par_bad_d  = 1'b0;
        if (!RX_IN) state_d = StStart;
      end
      StStart: begin
        if (smp_vld && smp) begin
          state_d = StIdle;
        end else if (end_bit) begin
          state_d = StData;
        end
      end
      StData: begin
        if (smp_vld) shreg_d = {smp, shreg_q[DATA_WIDTH-1:1]};
        if (end_bit && (bit_cnt == BIT_W'(DATA_WIDTH))) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (smp_vld) par_bad_d = (smp != exp_par);
        if (end_bit) state_d = StStop;
      end
      StStop: begin
        // Leave before the stop bit ends so a back-to-back start bit is seen.
        if (smp_vld) begin
          se_d    = !smp;
          pe_d    = par_bad_q;
          state_d = StIdle;
          if (smp && !par_bad_q) begin
            p_data_d = shreg_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the edge/bit counter, drives directed and random
// frames, and compares pulse counts and received bytes against a frame-level model.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          cnt_enable;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int            dv_cnt = 0;
  int            pe_cnt = 0;
  int            se_cnt = 0;
  int            overlap = 0;
  logic [DW-1:0] dv_data[$];
  int            dv_time[$];
  logic          prev_dv = 1'b0;
  logic          prev_se = 1'b0;
  logic          cen_after_dv = 1'bx;
  logic          cen_after_se = 1'bx;
  logic          cen_seen = 1'b0;

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .PRE_W      (PW),
    .BIT_W      (BW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_enable (cnt_enable),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Edge/bit counter living beside the controller.
  always @(posedge CLK) begin
    if (cnt_enable !== 1'b1) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == Prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always @(negedge CLK) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_data.push_back(P_DATA);
      dv_time.push_back(cyc);
    end
    if (par_err === 1'b1) pe_cnt++;
    if (stp_err === 1'b1) se_cnt++;
    if (data_valid === 1'b1 && (par_err === 1'b1 || stp_err === 1'b1)) overlap++;
    if (prev_dv) cen_after_dv = cnt_enable;
    if (prev_se) cen_after_se = cnt_enable;
    if (cnt_enable === 1'b1) cen_seen = 1'b1;
    prev_dv = (data_valid === 1'b1);
    prev_se = (stp_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_cfg(input int p, input bit pen, input bit ptyp);
    Prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
  endtask

  // Line-level frame: start, LSB-first data, optional parity, stop; each bit p clocks.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stopb, input int p);
    RX_IN = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(p);
    end
    if (pen) begin
      RX_IN = pbit;
      tick(p);
    end
    RX_IN = stopb;
    tick(p);
  endtask

  // Parity bit the sender should transmit: even makes the ones count even.
  function automatic bit good_parity(input logic [7:0] d, input bit ptyp);
    return bit'(($countones(d) % 2) != 0) ^ ptyp;
  endfunction

  initial begin
    int b_dv, b_pe, b_se, t0, dt, p;
    bit pen, ptyp, pbit, stopb, pbad, ok;
    logic [7:0] d;

    RST = 1'b0; RX_IN = 1'b1;
    set_cfg(8, 1'b0, 1'b0);
    tick(3);
    check("reset_ctl", 32'({cnt_enable, data_valid, par_err, stp_err}), 32'h0);
    check("reset_pdata", 32'(P_DATA), 32'h0);
    RST = 1'b1;
    tick(4);

    // 1: P=8, no parity, 0xA5
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    RX_IN = 1'b1;
    tick(16);
    check("t1_dv_count", 32'(dv_cnt - b_dv), 32'd1);
    check("t1_pdata", 32'(P_DATA), 32'hA5);
    check("t1_errs", 32'((pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    check("t1_cen_after_dv", 32'(cen_after_dv), 32'd0);
    dt = dv_time[dv_time.size()-1] - t0;
    check("t1_dv_in_stop_bit", 32'(dt > 9 * 8 && dt <= 10 * 8), 32'd1);

    // 2: P=16, even parity, 0x3C good then bad parity
    set_cfg(16, 1'b1, 1'b0);
    tick(2);
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
    RX_IN = 1'b1;
    tick(40);
    check("t2_dv_count", 32'(dv_cnt - b_dv), 32'd1);
    check("t2_pdata", 32'(P_DATA), 32'h3C);
    check("t2_no_par_err", 32'(pe_cnt - b_pe), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
    RX_IN = 1'b1;
    tick(40);
    check("t2b_par_err", 32'(pe_cnt - b_pe), 32'd1);
    check("t2b_no_dv", 32'(dv_cnt - b_dv), 32'd1);
    check("t2b_no_stp", 32'(se_cnt - b_se), 32'd0);
    check("t2b_pdata_held", 32'(P_DATA), 32'h3C);

    // 3: P=8, 0x55 with stop bit low, line kept low afterwards
    set_cfg(8, 1'b0, 1'b0);
    tick(2);
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8);
    tick(3);
    RX_IN = 1'b1;
    tick(24);
    check("t3_stp_err", 32'(se_cnt - b_se), 32'd1);
    check("t3_no_dv", 32'(dv_cnt - b_dv), 32'd0);
    check("t3_no_par", 32'(pe_cnt - b_pe), 32'd0);
    check("t3_restart", 32'(cen_after_se), 32'd1);

    // 4: P=8, 2-clock glitch
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    cen_seen = 1'b0;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(20);
    check("t4_started", 32'(cen_seen), 32'd1);
    check("t4_cen_low", 32'(cnt_enable), 32'd0);
    check("t4_no_pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);

    // 5: P=32, back-to-back 0x01 then 0xFE
    set_cfg(32, 1'b0, 1'b0);
    tick(2);
    b_dv = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 32);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 32);
    RX_IN = 1'b1;
    tick(70);
    check("t5_dv_count", 32'(dv_cnt - b_dv), 32'd2);
    if (dv_cnt - b_dv >= 2) begin
      check("t5_first", 32'(dv_data[dv_data.size()-2]), 32'h01);
      check("t5_second", 32'(dv_data[dv_data.size()-1]), 32'hFE);
      check("t5_spacing", 32'(dv_time[dv_time.size()-1] - dv_time[dv_time.size()-2]),
            32'(10 * 32));
    end

    // 6: reset during data bits of 0x81, then a clean 0x81
    set_cfg(8, 1'b0, 1'b0);
    tick(2);
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    RX_IN = 1'b0; tick(8);
    RX_IN = 1'b1; tick(8);
    RX_IN = 1'b0; tick(4);
    check("t6_in_frame", 32'(cnt_enable), 32'd1);
    RST = 1'b0; RX_IN = 1'b1;
    tick(1);
    check("t6_reset_ctl", 32'({cnt_enable, data_valid, par_err, stp_err}), 32'h0);
    check("t6_reset_pdata", 32'(P_DATA), 32'h0);
    RST = 1'b1;
    tick(20);
    check("t6_no_pulses", 32'((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se)), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
    RX_IN = 1'b1;
    tick(16);
    check("t6_dv_count", 32'(dv_cnt - b_dv), 32'd1);
    check("t6_pdata", 32'(P_DATA), 32'h81);

    // Random frames against the frame-level model
    for (int k = 0; k < 12; k++) begin
      case ($urandom % 3)
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pen   = bit'($urandom % 2);
      ptyp  = bit'($urandom % 2);
      d     = 8'($urandom);
      pbit  = good_parity(d, ptyp) ^ (($urandom % 4) == 0);
      stopb = (($urandom % 5) != 0);
      pbad  = pen && (pbit != good_parity(d, ptyp));
      ok    = stopb && !pbad;
      set_cfg(p, pen, ptyp);
      tick(2);
      b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
      send_frame(d, pen, pbit, stopb, p);
      RX_IN = 1'b1;
      tick(3 * p);
      check("rnd_dv", 32'(dv_cnt - b_dv), 32'(ok));
      check("rnd_par_err", 32'(pe_cnt - b_pe), 32'(pbad));
      check("rnd_stp_err", 32'(se_cnt - b_se), 32'(!stopb));
      if (ok) check("rnd_pdata", 32'(P_DATA), 32'(d));
    end

    check("dv_never_with_err", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
